// File: rtl/second_tick_unit.sv
// Qualifies a against inhibit b (out = a & ~b), with a registered copy, a rising-edge pulse
// and, when SECOND_TICK_EVT_CNT_EN is defined, a saturating count of those pulses.
module second_tick_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             out,
  output logic             out_q,
  output logic             out_rise,
  output logic [CNT_W-1:0] evt_cnt
);

  assign out = a & ~b;

  // Pulse is computed against the previous out_q, so the first qualified edge after reset counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= 1'b0;
      out_rise <= 1'b0;
    end else begin
      out_q    <= out;
      out_rise <= out & ~out_q;
    end
  end

`ifdef SECOND_TICK_EVT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Clear wins over a coincident increment; the count holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (clr) begin
      evt_cnt <= '0;
    end else if (out_rise && (evt_cnt != CNT_MAX)) begin
      evt_cnt <= evt_cnt + CNT_ONE;
    end
  end
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign evt_cnt    = '0;
`endif

endmodule

// File: tb/tb_second_tick_unit.sv
// Directed self-checking bench for second_tick_unit (CNT_W=2); counter checks follow SECOND_TICK_EVT_CNT_EN.
module tb_second_tick_unit;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             a;
  logic             b;
  logic             clr;
  logic             out;
  logic             out_q;
  logic             out_rise;
  logic [CNT_W-1:0] evt_cnt;

  int checks;
  int failures;

  second_tick_unit #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .clr      (clr),
    .out      (out),
    .out_q    (out_q),
    .out_rise (out_rise),
    .evt_cnt  (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_q !== 1'b0 || out_rise !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_regs: out_q=%b out_rise=%b required 0 0", out_q, out_rise);
    end
    checks++;
    if (evt_cnt !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_cnt: evt_cnt=%0d required 0", evt_cnt);
    end
    a = 1'b1;
    b = 1'b0;
    #1;
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_out_comb: out=%b required 1", out);
    end
    tick();
    checks++;
    if (out_q !== 1'b0 || out_rise !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_held: out_q=%b out_rise=%b required 0 0", out_q, out_rise);
    end
    @(negedge clk);
    a   = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_comb();
    logic [1:0] ab_vec [4];
    logic       exp_out [4];
    ab_vec  = '{2'b00, 2'b10, 2'b01, 2'b11};
    exp_out = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a = ab_vec[i][1];
      b = ab_vec[i][0];
      #10;
      checks++;
      if (out !== exp_out[i]) begin
        failures++;
        $display("[TB] FAIL comb_ab%b: out=%b required %b", ab_vec[i], out, exp_out[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic exp_rise [3];
    exp_rise = '{1'b1, 1'b0, 1'b0};
    @(negedge clk);
    a = 1'b0;
    b = 1'b0;
    tick();
    @(negedge clk);
    a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_q !== 1'b1 || out_rise !== exp_rise[i]) begin
        failures++;
        $display("[TB] FAIL hold_edge%0d: out_q=%b out_rise=%b required 1 %b", i, out_q, out_rise, exp_rise[i]);
      end
    end
  endtask

  task automatic test_toggle();
    logic b_vec [4];
    logic exp_q [4];
    int   pulses;
    b_vec  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_q  = '{1'b0, 1'b1, 1'b0, 1'b1};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 1'b1;
      b = b_vec[i];
      tick();
      if (out_rise === 1'b1) pulses++;
      checks++;
      if (out_q !== exp_q[i] || out_rise !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL toggle_step%0d: out_q=%b out_rise=%b required %b %b", i, out_q, out_rise, exp_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("[TB] FAIL toggle_pulses: counted %0d required 2", pulses);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_q !== 1'b0 || out_rise !== 1'b0 || evt_cnt !== 2'd0) begin
      failures++;
      $display("[TB] FAIL async_clear: out_q=%b out_rise=%b evt_cnt=%0d required 0 0 0", out_q, out_rise, evt_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    a   = 1'b1;
    b   = 1'b0;
    tick();
    checks++;
    if (out_q !== 1'b1 || out_rise !== 1'b1) begin
      failures++;
      $display("[TB] FAIL release_first: out_q=%b out_rise=%b required 1 1", out_q, out_rise);
    end
    tick();
    checks++;
    if (out_rise !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release_second: out_rise=%b required 0", out_rise);
    end
  endtask

  task automatic test_evt_cnt();
    logic [1:0] exp_cnt [5];
    @(negedge clk);
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`ifdef SECOND_TICK_EVT_CNT_EN
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    exp_cnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 1'b1;
`ifndef SECOND_TICK_EVT_CNT_EN
      clr = ~clr;
`endif
      tick();
      @(negedge clk);
      a = 1'b0;
      tick();
      checks++;
      if (evt_cnt !== exp_cnt[i]) begin
        failures++;
        $display("[TB] FAIL cnt_rise%0d: evt_cnt=%0d required %0d", i, evt_cnt, exp_cnt[i]);
      end
    end
    @(negedge clk);
    a = 1'b1;
    tick();
    @(negedge clk);
    a   = 1'b0;
    clr = 1'b1;
    tick();
    checks++;
    if (evt_cnt !== 2'd0) begin
      failures++;
      $display("[TB] FAIL cnt_clr_priority: evt_cnt=%0d required 0", evt_cnt);
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a        = 1'b0;
    b        = 1'b0;
    clr      = 1'b0;
    test_reset();
    test_comb();
    test_hold();
    test_toggle();
    test_async_reset();
    test_evt_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/second_tick_unit.md
Name: second_tick_unit

Overview:
- Two-input "second tick" qualifier: output is high only when input a is high and input b is low (a AND NOT b).
- Primary output is purely combinational; a registered copy and a rising-edge pulse are provided for clocked consumers.
- Used as a small gating/qualifier primitive in control paths.

Parameters:
CNT_W, 8, width of the optional qualified-event counter (legal 1..32)

Ports:
clk  input  1  single system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
a  input  1  primary enable input
b  input  1  inhibit input
clr  input  1  synchronous clear of event counter (optional feature only; ignored otherwise)
out  output  1  combinational result, a & ~b
out_q  output  1  out registered on clk
out_rise  output  1  one-cycle pulse when out_q transitions 0->1
evt_cnt  output  CNT_W  saturating count of out_rise pulses (optional feature; else tied 0)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- out = a & ~b, zero latency, no clock dependency, valid during reset.
- Truth table for out:
  - a=0,b=0 -> 0
  - a=1,b=0 -> 1
  - a=0,b=1 -> 0
  - a=1,b=1 -> 0
- X/Z on a or b is not masked; propagates per standard logic.
- out_q: on rising clk, out_q <= out. Latency: 1 cycle.
- out_rise: registered; out_rise <= out & ~out_q at each rising clk.
  - High for exactly one cycle, the cycle in which out_q first becomes 1.
- Reset asserted (async): out_q=0, out_rise=0, evt_cnt=0 immediately, held while rst=1.
- First clk edge after rst deasserts samples normally.
  - If out=1 at that edge: out_q=1 and out_rise=1 (rise from reset state counts).
- Reset mid-operation: registered state cleared at once; no pulse is generated by the reset itself.
- Glitches on a/b between clock edges affect out only, never out_q/out_rise.

Optional Feature:
- Macro SECOND_TICK_EVT_CNT_EN.
- Defined:
  - evt_cnt increments by 1 on each cycle with out_rise=1.
  - Saturates at 2^CNT_W-1.
  - clr=1 at a rising edge sets evt_cnt=0.
  - clr has priority over a simultaneous increment.
- Not defined:
  - evt_cnt is constant 0.
  - clr is unused.
  - No counter flops are inferred.

Test Plan:
- rst=1, then release; drive (a,b)=00,10,01,11, 10 ns each -> out=0,1,0,0 respectively, combinationally, independent of clk.
- Hold (a,b)=10 for 3 clocks from out_q=0 -> out_q=1 after 1st edge; out_rise=1 for exactly that cycle, 0 after.
- Toggle (a,b) 10->11->10 across clock edges -> out_rise pulses twice; out_q follows out with 1-cycle lag.
- Assert rst asynchronously while out_q=1 -> out_q, out_rise, evt_cnt go 0 without a clock edge.
  - Release with (a,b)=10 -> out_rise=1 on the first edge.
- With SECOND_TICK_EVT_CNT_EN, CNT_W=2: generate 5 rises -> evt_cnt=1,2,3,3,3.
  - Then clr=1 coincident with a rise -> evt_cnt=0.
- Without SECOND_TICK_EVT_CNT_EN: any stimulus, clr toggled -> evt_cnt stays 0.
